// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions for the instruction encoder and the control unit:
// mnemonic codes, opcode/funct constants, field widths and bit positions, the
// request payload struct and small word-assembly helpers.
package mips_isa_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned MNEM_W  = 4;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned TGT_W   = 26;

  // Field bit positions inside an instruction word
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_LSB  = 11;

  // Mnemonic codes; 11..15 are illegal
  typedef enum logic [MNEM_W-1:0] {
    MN_NOP  = 4'd0,
    MN_ADD  = 4'd1,
    MN_SUB  = 4'd2,
    MN_AND  = 4'd3,
    MN_OR   = 4'd4,
    MN_SLT  = 4'd5,
    MN_LW   = 4'd6,
    MN_SW   = 4'd7,
    MN_ADDI = 4'd8,
    MN_BEQ  = 4'd9,
    MN_J    = 4'd10
  } mnem_e;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'h2A;

  // Decoded operation request as it arrives on the loader input
  typedef struct packed {
    logic [MNEM_W-1:0] mnem;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [IMM_W-1:0]  imm;
    logic [TGT_W-1:0]  target;
  } instr_req_t;

  // R-type: {opcode 0, rs, rt, rd, shamt 0, funct}
  function automatic logic [WORD_W-1:0] enc_r(input logic [FUNCT_W-1:0] funct,
                                               input logic [REG_W-1:0]   rs,
                                               input logic [REG_W-1:0]   rt,
                                               input logic [REG_W-1:0]   rd);
    return (WORD_W'(OP_RTYPE) << OPC_LSB) | (WORD_W'(rs) << RS_LSB) |
           (WORD_W'(rt) << RT_LSB) | (WORD_W'(rd) << RD_LSB) | WORD_W'(funct);
  endfunction

  // I-type: {opcode, rs, rt, imm}
  function automatic logic [WORD_W-1:0] enc_i(input logic [OPC_W-1:0] op,
                                               input logic [REG_W-1:0] rs,
                                               input logic [REG_W-1:0] rt,
                                               input logic [IMM_W-1:0] imm);
    return (WORD_W'(op) << OPC_LSB) | (WORD_W'(rs) << RS_LSB) |
           (WORD_W'(rt) << RT_LSB) | WORD_W'(imm);
  endfunction

  // J-type: {opcode 2, target}
  function automatic logic [WORD_W-1:0] enc_j(input logic [TGT_W-1:0] target);
    return (WORD_W'(OP_J) << OPC_LSB) | WORD_W'(target);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational encoder: mnemonic plus fields -> 32-bit instruction word and a
// legal flag. Fields a mnemonic does not use are ignored.
// Ports:
//   req_i      request payload (mnemonic, rs, rt, rd, imm, target)
//   word_c_o   encoded instruction (0 when illegal)
//   legal_c_o  1 when the mnemonic is in the supported subset
module instr_pack
  import mips_isa_pkg::*;
(
  input  instr_req_t        req_i,
  output logic [WORD_W-1:0] word_c_o,
  output logic              legal_c_o
);

  always_comb begin
    word_c_o  = '0;
    legal_c_o = 1'b1;
    case (req_i.mnem)
      MN_NOP:  word_c_o = '0;
      MN_ADD:  word_c_o = enc_r(FUNCT_ADD, req_i.rs, req_i.rt, req_i.rd);
      MN_SUB:  word_c_o = enc_r(FUNCT_SUB, req_i.rs, req_i.rt, req_i.rd);
      MN_AND:  word_c_o = enc_r(FUNCT_AND, req_i.rs, req_i.rt, req_i.rd);
      MN_OR:   word_c_o = enc_r(FUNCT_OR,  req_i.rs, req_i.rt, req_i.rd);
      MN_SLT:  word_c_o = enc_r(FUNCT_SLT, req_i.rs, req_i.rt, req_i.rd);
      MN_LW:   word_c_o = enc_i(OP_LW,   req_i.rs, req_i.rt, req_i.imm);
      MN_SW:   word_c_o = enc_i(OP_SW,   req_i.rs, req_i.rt, req_i.imm);
      MN_ADDI: word_c_o = enc_i(OP_ADDI, req_i.rs, req_i.rt, req_i.imm);
      MN_BEQ:  word_c_o = enc_i(OP_BEQ,  req_i.rs, req_i.rt, req_i.imm);
      MN_J:    word_c_o = enc_j(req_i.target);
      default: legal_c_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program preloader: encodes a stream of operation requests into MIPS words
// and writes them to consecutive instruction-memory addresses, one session
// at a time (start opens, finish or a full DEPTH closes).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, finish                 session open / early close pulses
//   in_valid, in_ready            request handshake
//   in_mnem, in_rs/rt/rd, in_imm, in_target   request fields
//   imem_we, imem_addr, imem_wdata            registered memory write port
//   count                         words written this session
//   done                          session closed
//   err                           sticky illegal-mnemonic flag
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                finish,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MNEM_W-1:0]   in_mnem,
  input  logic [REG_W-1:0]    in_rs,
  input  logic [REG_W-1:0]    in_rt,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [IMM_W-1:0]    in_imm,
  input  logic [TGT_W-1:0]    in_target,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [WORD_W-1:0]   imem_wdata,
  output logic [ADDR_W:0]     count,
  output logic                done,
  output logic                err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic                in_ready_q;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [WORD_W-1:0]   imem_wdata_q;
  logic [CNT_W-1:0]    count_q;
  logic                done_q;
  logic                err_q;

  instr_req_t          req;
  logic [WORD_W-1:0]   word_c;
  logic                legal_c;
  logic                accept_c;
  logic                last_c;

  assign req = '{mnem: in_mnem, rs: in_rs, rt: in_rt, rd: in_rd,
                 imm: in_imm, target: in_target};

  instr_pack u_pack (
    .req_i     (req),
    .word_c_o  (word_c),
    .legal_c_o (legal_c)
  );

  // in_ready_q is only set while in LOAD, so it doubles as the state gate
  assign accept_c = in_valid & in_ready_q;
  // Beat that fills the session; the FSM closes on this same edge
  assign last_c   = accept_c & legal_c & (count_q == LAST_CNT);

  // Session FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_LOAD;
            in_ready_q <= 1'b1;
            count_q    <= '0;
            err_q      <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept_c) begin
            if (legal_c) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= count_q[ADDR_W-1:0];
              imem_wdata_q <= word_c;
              count_q      <= count_q + CNT_W'(1);
            end else begin
              err_q <= 1'b1;
            end
          end
          if (finish || last_c) begin
            state_q    <= ST_DONE;
            in_ready_q <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_q    <= ST_LOAD;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
            count_q    <= '0;
            err_q      <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign count      = count_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (DEPTH=4): a table of single-beat
// sessions plus hand-written multi-cycle sequences.
module tb_instr_encoder_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic               clk;
  logic               rst;
  logic               start;
  logic               finish;
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_mnem;
  logic [4:0]         in_rs;
  logic [4:0]         in_rt;
  logic [4:0]         in_rd;
  logic [15:0]        in_imm;
  logic [25:0]        in_target;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [31:0]        imem_wdata;
  logic [ADDR_W:0]    count;
  logic               done;
  logic               err;

  int total = 0;
  int bad   = 0;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .finish     (finish),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mnem    (in_mnem),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_target  (in_target),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic beat(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    in_valid  = 1'b1;
    in_mnem   = m;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_imm    = imm;
    in_target = tgt;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"nop",   4'd0,  5'd9,  5'd9,  5'd9,  16'h1234, 26'h0,       1'b1, 32'h0000_0000};
    vecs[1]  = '{"add",   4'd1,  5'd1,  5'd2,  5'd3,  16'h0,    26'h0,       1'b1, 32'h0022_1820};
    vecs[2]  = '{"sub",   4'd2,  5'd4,  5'd5,  5'd6,  16'h0,    26'h0,       1'b1, 32'h0085_3022};
    vecs[3]  = '{"and",   4'd3,  5'd7,  5'd8,  5'd9,  16'h0,    26'h0,       1'b1, 32'h00E8_4824};
    vecs[4]  = '{"or",    4'd4,  5'd31, 5'd0,  5'd31, 16'hBEEF, 26'h3FFFFFF, 1'b1, 32'h03E0_F825};
    vecs[5]  = '{"slt",   4'd5,  5'd2,  5'd3,  5'd1,  16'h0,    26'h0,       1'b1, 32'h0043_082A};
    vecs[6]  = '{"lw",    4'd6,  5'd29, 5'd8,  5'd0,  16'h0004, 26'h0,       1'b1, 32'h8FA8_0004};
    vecs[7]  = '{"sw",    4'd7,  5'd29, 5'd31, 5'd0,  16'hFFFC, 26'h0,       1'b1, 32'hAFBF_FFFC};
    vecs[8]  = '{"addi",  4'd8,  5'd0,  5'd1,  5'd5,  16'h7FFF, 26'h0,       1'b1, 32'h2001_7FFF};
    vecs[9]  = '{"beq",   4'd9,  5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,       1'b1, 32'h1022_FFFF};
    vecs[10] = '{"j",     4'd10, 5'd7,  5'd7,  5'd7,  16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h0BFF_FFFF};
    vecs[11] = '{"ill_b", 4'hB,  5'd1,  5'd2,  5'd3,  16'h0,    26'h0,       1'b0, 32'h0000_0000};
    vecs[12] = '{"ill_f", 4'hF,  5'd1,  5'd2,  5'd3,  16'h0,    26'h0,       1'b0, 32'h0000_0000};

    rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we",    32'(imem_we),  32'd0);
    chk("rst_addr",  32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata,    32'd0);
    chk("rst_count", 32'(count),    32'd0);
    chk("rst_done",  32'(done),     32'd0);
    chk("rst_err",   32'(err),      32'd0);

    // Table: each vector is its own session, the beat coinciding with finish
    for (int i = 0; i < 13; i++) begin
      pulse_start();
      chk({vecs[i].name, "_ready"}, 32'(in_ready), 32'd1);
      beat(vecs[i].mnem, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].tgt);
      finish = 1'b1;
      tick();
      in_valid = 1'b0;
      finish   = 1'b0;
      chk({vecs[i].name, "_we"}, 32'(imem_we), 32'(vecs[i].legal));
      chk({vecs[i].name, "_count"}, 32'(count), 32'(vecs[i].legal));
      chk({vecs[i].name, "_err"}, 32'(err), 32'(!vecs[i].legal));
      chk({vecs[i].name, "_done"}, 32'(done), 32'd1);
      if (vecs[i].legal) begin
        chk({vecs[i].name, "_addr"}, 32'(imem_addr), 32'd0);
        chk({vecs[i].name, "_wdata"}, imem_wdata, vecs[i].word);
      end
      tick();
      chk({vecs[i].name, "_we_pulse"}, 32'(imem_we), 32'd0);
    end

    // Back-to-back LW, BEQ, J
    pulse_start();
    beat(4'd6, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
    tick();
    chk("b2b_we0", 32'(imem_we), 32'd1);
    chk("b2b_addr0", 32'(imem_addr), 32'd0);
    chk("b2b_wdata0", imem_wdata, 32'h8FA8_0004);
    beat(4'd9, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
    tick();
    chk("b2b_we1", 32'(imem_we), 32'd1);
    chk("b2b_addr1", 32'(imem_addr), 32'd1);
    chk("b2b_wdata1", imem_wdata, 32'h1022_FFFF);
    beat(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
    tick();
    in_valid = 1'b0;
    chk("b2b_we2", 32'(imem_we), 32'd1);
    chk("b2b_addr2", 32'(imem_addr), 32'd2);
    chk("b2b_wdata2", imem_wdata, 32'h0800_0010);
    chk("b2b_count", 32'(count), 32'd3);
    tick();
    chk("b2b_idle_we", 32'(imem_we), 32'd0);
    chk("b2b_hold_addr", 32'(imem_addr), 32'd2);
    chk("b2b_hold_wdata", imem_wdata, 32'h0800_0010);
    chk("b2b_not_done", 32'(done), 32'd0);
    pulse_finish();
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_ready_low", 32'(in_ready), 32'd0);

    // Illegal beat between two legal ones; start inside LOAD is ignored
    pulse_start();
    beat(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    tick();
    chk("ill_first_addr", 32'(imem_addr), 32'd0);
    beat(4'hF, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    tick();
    chk("ill_no_we", 32'(imem_we), 32'd0);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_count", 32'(count), 32'd1);
    beat(4'd2, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    chk("ill_second_we", 32'(imem_we), 32'd1);
    chk("ill_second_addr", 32'(imem_addr), 32'd1);
    chk("ill_second_wdata", imem_wdata, 32'h0085_3022);
    chk("ill_start_ignored_count", 32'(count), 32'd2);
    chk("ill_err_sticky", 32'(err), 32'd1);
    pulse_finish();

    // DEPTH limit: valid held for 6 cycles
    pulse_start();
    chk("full_err_cleared", 32'(err), 32'd0);
    chk("full_count0", 32'(count), 32'd0);
    for (int i = 0; i < 6; i++) begin
      beat(4'd8, 5'd0, 5'd1, 5'd0, 16'(i), 26'h0);
      tick();
      if (i < 4) begin
        chk($sformatf("full_we%0d", i), 32'(imem_we), 32'd1);
        chk($sformatf("full_addr%0d", i), 32'(imem_addr), 32'(i));
        chk($sformatf("full_wdata%0d", i), imem_wdata, 32'h2001_0000 | 32'(i));
      end else begin
        chk($sformatf("full_no_we%0d", i), 32'(imem_we), 32'd0);
      end
      if (i == 3) begin
        chk("full_ready_drop", 32'(in_ready), 32'd0);
        chk("full_done", 32'(done), 32'd1);
      end
    end
    in_valid = 1'b0;
    chk("full_count", 32'(count), 32'd4);
    chk("full_addr_hold", 32'(imem_addr), 32'd3);
    pulse_finish();
    chk("full_finish_ignored", 32'(done), 32'd1);

    // finish with a coincident beat, then restart clears count/err
    pulse_start();
    beat(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    tick();
    beat(4'hB, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    tick();
    chk("fin_err", 32'(err), 32'd1);
    beat(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    finish = 1'b1;
    tick();
    finish   = 1'b0;
    in_valid = 1'b0;
    chk("fin_we", 32'(imem_we), 32'd1);
    chk("fin_addr", 32'(imem_addr), 32'd1);
    chk("fin_wdata", imem_wdata, 32'h0022_1820);
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_count", 32'(count), 32'd2);
    pulse_start();
    chk("restart_count", 32'(count), 32'd0);
    chk("restart_err", 32'(err), 32'd0);
    chk("restart_done", 32'(done), 32'd0);
    beat(4'd5, 5'd2, 5'd3, 5'd1, 16'h0, 26'h0);
    tick();
    in_valid = 1'b0;
    chk("restart_addr", 32'(imem_addr), 32'd0);
    chk("restart_wdata", imem_wdata, 32'h0043_082A);

    // rst while a beat is presented right after an accept
    beat(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    tick();
    chk("prerst_we", 32'(imem_we), 32'd1);
    beat(4'd2, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst2_we", 32'(imem_we), 32'd0);
    chk("rst2_addr", 32'(imem_addr), 32'd0);
    chk("rst2_wdata", imem_wdata, 32'd0);
    chk("rst2_count", 32'(count), 32'd0);
    chk("rst2_done", 32'(done), 32'd0);
    chk("rst2_err", 32'(err), 32'd0);
    chk("rst2_ready", 32'(in_ready), 32'd0);
    beat(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    tick();
    in_valid = 1'b0;
    chk("rst2_idle_no_we", 32'(imem_we), 32'd0);
    chk("rst2_idle_count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
